// File: rtl/writeback_regfile.sv
// -----------------------------------------------------------------------------
// writeback_regfile
//
// Write-back stage of the 5-stage pipeline together with the 32x32
// architectural register file.
//
// The stage decodes the 104-bit MEM_WB bus and picks the write-back value from
// the ALU result, the load data or PC+4. It commits that value into the
// register file and serves the two ID-stage read ports. Each read port has a
// same-cycle write-through bypass. The stage also exports the WB forwarding
// triple and keeps a count of committed register writes.
//
// Ports
//   clk              in   1      clock, all state updates on rising edge
//   rst_n            in   1      asynchronous reset, active low
//   MEM_WB           in   104    [31:0] ALUResult, [63:32] ReadData,
//                                [68:64] WriteRegister, [69] RegWrite,
//                                [71:70] MemtoReg, [103:72] PC_plus4
//   rd_addr1         in   5      ID read port 1 address (rs)
//   rd_addr2         in   5      ID read port 2 address (rt)
//   rd_data1         out  32     read port 1 data, combinational
//   rd_data2         out  32     read port 2 data, combinational
//   WB_RegWrite      out  1      effective write enable (RegWrite && rd != 0)
//   WB_WriteRegister out  5      destination register from MEM_WB
//   WB_WriteData     out  32     selected write-back value
//   wb_retire_cnt    out  CNT_W  committed register writes since reset
//
// There is no handshake on this stage. MEM_WB is taken to be valid on every
// cycle, and a bubble is encoded as RegWrite=0. The read ports are plain
// combinational lookups with no valid/ready.
// -----------------------------------------------------------------------------
module writeback_regfile #(
    parameter logic [31:0] SP_INIT = 32'h0000_03FC,
    parameter int          CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [103:0]      MEM_WB,
    input  logic [4:0]        rd_addr1,
    input  logic [4:0]        rd_addr2,
    output logic [31:0]       rd_data1,
    output logic [31:0]       rd_data2,
    output logic              WB_RegWrite,
    output logic [4:0]        WB_WriteRegister,
    output logic [31:0]       WB_WriteData,
    output logic [CNT_W-1:0]  wb_retire_cnt
);

    // MEM_WB field extraction
    logic [31:0] w_alu_result;
    logic [31:0] w_read_data;
    logic [4:0]  w_write_reg;
    logic        w_reg_write;
    logic [1:0]  w_mem_to_reg;
    logic [31:0] w_pc_plus4;

    assign w_alu_result = MEM_WB[31:0];
    assign w_read_data  = MEM_WB[63:32];
    assign w_write_reg  = MEM_WB[68:64];
    assign w_reg_write  = MEM_WB[69];
    assign w_mem_to_reg = MEM_WB[71:70];
    assign w_pc_plus4   = MEM_WB[103:72];

    // Write-back value select. The reserved encoding 11 falls back to the
    // ALU result, so every MemtoReg value maps to a defined source.
    logic [31:0] w_wb_data;

    always_comb begin
        w_wb_data = w_alu_result;
        case (w_mem_to_reg)
            2'b01:   w_wb_data = w_read_data;
            2'b10:   w_wb_data = w_pc_plus4;
            default: w_wb_data = w_alu_result;
        endcase
    end

    // A write that targets $0 is squashed here. As a result it neither
    // commits, bypasses nor counts as a retired write.
    logic w_wb_we;
    assign w_wb_we = w_reg_write && (w_write_reg != 5'd0);

    assign WB_RegWrite      = w_wb_we;
    assign WB_WriteRegister = w_write_reg;
    assign WB_WriteData     = w_wb_data;

    // Register storage and retire counter
    logic [31:0]      r_regs [32];
    logic [CNT_W-1:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= (i == 29) ? SP_INIT : 32'd0;
            end
            r_retire_cnt <= '0;
        end else begin
            if (w_wb_we) begin
                r_regs[w_write_reg] <= w_wb_data;
                // Wraps silently at the top of its range.
                r_retire_cnt        <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign wb_retire_cnt = r_retire_cnt;

    // Asynchronous read ports with write-through bypass. Address 0 always
    // reads zero, whatever sits in storage or on the bypass path. Each port
    // resolves independently, so both may hit the bypass in the same cycle.
    always_comb begin
        rd_data1 = r_regs[rd_addr1];
        if (rd_addr1 == 5'd0) begin
            rd_data1 = 32'd0;
        end else if (w_wb_we && (rd_addr1 == w_write_reg)) begin
            rd_data1 = w_wb_data;
        end
    end

    always_comb begin
        rd_data2 = r_regs[rd_addr2];
        if (rd_addr2 == 5'd0) begin
            rd_data2 = 32'd0;
        end else if (w_wb_we && (rd_addr2 == w_write_reg)) begin
            rd_data2 = w_wb_data;
        end
    end

endmodule
